vectorgen_ctrl_rx: RTL and testbench
====================================

// Module: vectorgen_ctrl_rx
// PURPOSE
//  Receiving end of the PU_controller -> vector-generator control interface.
//  Captures the 9-bit ctrl word, sequences reads from the input-activation FIFO into a
//  NUM_PE-wide window register and emits vectors to the PE array.
//  Drives vectorgen_ready back to PU_controller to stall it when the FIFO cannot supply data.
//  Sits between the input buffer FIFO and the PE array inside each PU.
// PARAMETERS
//  NUM_PE        4   window / output vector width in elements
//  DATA_WIDTH    16  bits per element
//  VECGEN_CTRL_W 9   ctrl word width (fixed field map below; must be 9)
//  ROW_CNT_W     10  width of row / column / feature-map counters
// PORTS
//  clk            in   1                   clock, all state on rising edge
//  reset_n        in   1                   asynchronous, active-low reset
//  ctrl           in   VECGEN_CTRL_W       control word from PU_controller
//  vectorgen_ready out 1                   high = a ctrl word presented this cycle is accepted
//  fifo_empty     in   1                   input FIFO empty
//  fifo_data      in   DATA_WIDTH          input FIFO head word (valid while !fifo_empty)
//  fifo_pop       out  1                   pop FIFO head this cycle
//  rd_req         out  1                   one-cycle read request to upstream buffer
//  vector_out     out  NUM_PE*DATA_WIDTH   vector to PEs, element 0 in LSBs
//  vector_valid   out  1                   one-cycle strobe, vector_out valid
//  vector_endrow  out  1                   qualifies vector_valid: last vector of row
//  fm_done        out  1                   one-cycle pulse on nextfm
//  row_count      out  ROW_CNT_W           rows completed in current feature map
//  protocol_err   out  1                   sticky protocol violation flag
// BEHAVIOUR
//  Field map, MSB->LSB: [8]nextData [7]nextRead [6]pop [5]shift [4]nextrow [3]skip
//    [2]endrow [1]start [0]nextfm. A word is "active" when any bit is set.
//  Reset: all outputs 0 except vectorgen_ready=1; window, counters cleared; state IDLE.
//  States: IDLE, ACTIVE, STALL.
//   IDLE:   ready=1; ignores every word except start, which -> ACTIVE.
//           Any other active word -> protocol_err.
//   ACTIVE: ready=1; active word captured into ctrl_q and executed in the same edge
//           if it needs no FIFO data or !fifo_empty; otherwise latched -> STALL.
//   STALL:  ready=0; waits for !fifo_empty, executes ctrl_q, -> ACTIVE.
//           Any active ctrl while in STALL: protocol_err, word dropped.
//  Execution order within one word (all at one edge):
//   start clears window/counters -> skip -> nextData -> shift -> pop -> nextrow/endrow/nextfm.
//  Per-field actions:
//   skip      fifo_pop=1, word discarded.
//   nextData  fifo_pop=1; window shifts down one element: win[i]<=win[i+1];
//             win[NUM_PE-1]<=fifo_data.
//   both skip+nextData: protocol_err; only the skip is executed (one pop).
//   shift     shifts window down one element, zero-fill at top (padding).
//             Shift combined with nextData is a single shift-in of fifo_data, not two shifts.
//   pop       vector_out<=window after this word's update; vector_valid=1 next cycle (latency 1).
//   endrow    vector_endrow=1 alongside that pop's vector_valid;
//             endrow without pop sets no vector, col_count cleared.
//   nextrow   row_count++, col_count cleared; row_count saturates at all-ones.
//   nextfm    fm_done pulse next cycle; row_count cleared.
//   nextRead  rd_req=1 next cycle, one cycle only.
//   start     while ACTIVE: restart (clear); fields other than start are still executed.
//  col_count increments on each pop, wraps at 2^ROW_CNT_W.
//  fifo_pop asserted combinationally in the cycle the word executes (never when fifo_empty).
//  protocol_err cleared only by reset.
//  reset_n low mid-STALL: pending word discarded, no pop issued.
// TESTING
//  1 Reset, then start then 4x nextData, FIFO holds 1,2,3,4, then pop ->
//    vector_out={4,3,2,1} (elem0=1), vector_valid one cycle later, 4 fifo_pop pulses.
//  2 nextData with fifo_empty=1 for 5 cycles -> ready=0 for 5 cycles, no fifo_pop;
//    fifo 0x00AA arrives -> single pop, ready=1 next cycle.
//  3 Window {4,3,2,1}, shift|pop -> vector_out={0,4,3,2}; endrow|pop -> vector_endrow=1 with valid.
//  4 3x nextrow then nextfm -> row_count 3 then 0; fm_done one-cycle pulse; nextRead -> one rd_req pulse.
//  5 pop before start / ctrl during STALL / skip|nextData -> protocol_err=1 and stays 1;
//    skip|nextData consumes exactly one FIFO word.
//  6 Assert reset_n=0 mid-STALL -> outputs return to reset values asynchronously;
//    no fifo_pop after release.

Source files
------------

// File: rtl/vectorgen_ctrl_rx.sv
// Vector-generator side of the PU_controller control link: decodes 9-bit ctrl words,
// pulls activations from the input FIFO into a NUM_PE-wide window and emits vectors.
module vectorgen_ctrl_rx #(
    parameter int NUM_PE        = 4,
    parameter int DATA_WIDTH    = 16,
    parameter int VECGEN_CTRL_W = 9,
    parameter int ROW_CNT_W     = 10
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [VECGEN_CTRL_W-1:0]       ctrl,
    output logic                           vectorgen_ready,
    input  logic                           fifo_empty,
    input  logic [DATA_WIDTH-1:0]          fifo_data,
    output logic                           fifo_pop,
    output logic                           rd_req,
    output logic [NUM_PE*DATA_WIDTH-1:0]   vector_out,
    output logic                           vector_valid,
    output logic                           vector_endrow,
    output logic                           fm_done,
    output logic [ROW_CNT_W-1:0]           row_count,
    output logic                           protocol_err
);

    localparam int F_NEXTFM   = 0;
    localparam int F_START    = 1;
    localparam int F_ENDROW   = 2;
    localparam int F_SKIP     = 3;
    localparam int F_NEXTROW  = 4;
    localparam int F_SHIFT    = 5;
    localparam int F_POP      = 6;
    localparam int F_NEXTREAD = 7;
    localparam int F_NEXTDATA = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_STALL  = 2'd2;

    logic [1:0]                            state;
    logic [1:0]                            state_next;
    logic [VECGEN_CTRL_W-1:0]              ctrl_q;
    logic [NUM_PE-1:0][DATA_WIDTH-1:0]     win;
    logic [NUM_PE-1:0][DATA_WIDTH-1:0]     win_base;
    logic [NUM_PE-1:0][DATA_WIDTH-1:0]     win_next;
    logic [ROW_CNT_W-1:0]                  row_cnt;
    logic [ROW_CNT_W-1:0]                  row_next;
    logic [ROW_CNT_W-1:0]                  col_cnt;
    logic [ROW_CNT_W-1:0]                  col_next;

    logic                                  ctrl_active;
    logic                                  needs_fifo;
    logic                                  exec_en;
    logic [VECGEN_CTRL_W-1:0]              exec_word;
    logic                                  hold_word;
    logic                                  drop_err;
    logic                                  start_idle;

    logic do_start, do_skip, do_data, do_shift, do_pop;
    logic do_endrow, do_nextrow, do_nextfm, do_read, both_err, clear;

    assign ctrl_active = |ctrl;
    assign needs_fifo  = ctrl[F_SKIP] | ctrl[F_NEXTDATA];

    // Decide whether this cycle executes a word, parks it in ctrl_q, or rejects it.
    always_comb begin
        state_next = state;
        exec_en    = 1'b0;
        exec_word  = '0;
        hold_word  = 1'b0;
        drop_err   = 1'b0;
        start_idle = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ctrl[F_START]) begin
                    start_idle = 1'b1;
                    state_next = ST_ACTIVE;
                end else if (ctrl_active) begin
                    drop_err = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (ctrl_active) begin
                    if (needs_fifo && fifo_empty) begin
                        hold_word  = 1'b1;
                        state_next = ST_STALL;
                    end else begin
                        exec_en   = 1'b1;
                        exec_word = ctrl;
                    end
                end
            end
            ST_STALL: begin
                if (ctrl_active) begin
                    drop_err = 1'b1;
                end
                if (!fifo_empty) begin
                    exec_en    = 1'b1;
                    exec_word  = ctrl_q;
                    state_next = ST_ACTIVE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign do_start   = exec_en & exec_word[F_START];
    assign do_skip    = exec_en & exec_word[F_SKIP];
    assign do_data    = exec_en & exec_word[F_NEXTDATA] & ~exec_word[F_SKIP];
    assign do_shift   = exec_en & exec_word[F_SHIFT];
    assign do_pop     = exec_en & exec_word[F_POP];
    assign do_endrow  = exec_en & exec_word[F_ENDROW];
    assign do_nextrow = exec_en & exec_word[F_NEXTROW];
    assign do_nextfm  = exec_en & exec_word[F_NEXTFM];
    assign do_read    = exec_en & exec_word[F_NEXTREAD];
    assign both_err   = exec_en & exec_word[F_SKIP] & exec_word[F_NEXTDATA];
    assign clear      = start_idle | do_start;

    assign fifo_pop        = do_skip | do_data;
    assign vectorgen_ready = (state != ST_STALL);
    assign row_count       = row_cnt;

    // A nextData that rides along with shift is one shift-in, not two shifts.
    always_comb begin
        win_base = clear ? '0 : win;
        win_next = win_base;
        if (do_data || do_shift) begin
            for (int i = 0; i < NUM_PE - 1; i++) begin
                win_next[i] = win_base[i+1];
            end
            win_next[NUM_PE-1] = do_data ? fifo_data : '0;
        end
    end

    always_comb begin
        row_next = clear ? '0 : row_cnt;
        if (do_nextrow && (row_next != '1)) begin
            row_next = row_next + 1'b1;
        end
        if (do_nextfm) begin
            row_next = '0;
        end
        col_next = clear ? '0 : col_cnt;
        if (do_pop) begin
            col_next = col_next + 1'b1;
        end
        if (do_endrow || do_nextrow) begin
            col_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            ctrl_q        <= '0;
            win           <= '0;
            row_cnt       <= '0;
            col_cnt       <= '0;
            vector_out    <= '0;
            vector_valid  <= 1'b0;
            vector_endrow <= 1'b0;
            fm_done       <= 1'b0;
            rd_req        <= 1'b0;
            protocol_err  <= 1'b0;
        end else begin
            state         <= state_next;
            win           <= win_next;
            row_cnt       <= row_next;
            col_cnt       <= col_next;
            vector_valid  <= do_pop;
            vector_endrow <= do_pop & do_endrow;
            fm_done       <= do_nextfm;
            rd_req        <= do_read;
            if (hold_word) begin
                ctrl_q <= ctrl;
            end
            if (do_pop) begin
                vector_out <= win_next;
            end
            if (drop_err || both_err) begin
                protocol_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vectorgen_ctrl_rx.sv
// Self-checking bench for vectorgen_ctrl_rx: a queue-based model tracks expected outputs
// every cycle, and directed scenarios pin key values with hand-computed literals.
module tb_vectorgen_ctrl_rx;

    localparam logic [8:0] C_NEXTFM   = 9'h001;
    localparam logic [8:0] C_START    = 9'h002;
    localparam logic [8:0] C_ENDROW   = 9'h004;
    localparam logic [8:0] C_SKIP     = 9'h008;
    localparam logic [8:0] C_NEXTROW  = 9'h010;
    localparam logic [8:0] C_SHIFT    = 9'h020;
    localparam logic [8:0] C_POP      = 9'h040;
    localparam logic [8:0] C_NEXTREAD = 9'h080;
    localparam logic [8:0] C_NEXTDATA = 9'h100;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [8:0]  ctrl = '0;
    logic        vectorgen_ready;
    logic        fifo_empty = 1'b1;
    logic [15:0] fifo_data = '0;
    logic        fifo_pop;
    logic        rd_req;
    logic [63:0] vector_out;
    logic        vector_valid;
    logic        vector_endrow;
    logic        fm_done;
    logic [9:0]  row_count;
    logic        protocol_err;

    int check_count = 0;
    int pass_count  = 0;
    int pop_total   = 0;
    bit cmp_en      = 1'b0;
    bit pop_pending = 1'b0;
    logic [15:0] fifo_q[$];

    vectorgen_ctrl_rx dut (
        .clk(clk), .reset_n(reset_n), .ctrl(ctrl), .vectorgen_ready(vectorgen_ready),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_pop(fifo_pop),
        .rd_req(rd_req), .vector_out(vector_out), .vector_valid(vector_valid),
        .vector_endrow(vector_endrow), .fm_done(fm_done), .row_count(row_count),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    endtask

    task automatic refreshFifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? 16'h0 : fifo_q[0];
    endtask

    // FIFO behaviour: the head word leaves after a cycle in which the DUT popped it.
    always @(negedge clk) begin
        pop_pending = fifo_pop;
        if (fifo_pop) pop_total++;
    end

    always @(posedge clk) begin
        #1;
        if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
        pop_pending = 1'b0;
        refreshFifo();
    end

    // Behavioural model: running flag, waiting flag with a held word, window as a queue.
    bit          m_run = 1'b0;
    bit          m_wait = 1'b0;
    logic [8:0]  m_held = '0;
    logic [15:0] m_win[$] = '{16'h0, 16'h0, 16'h0, 16'h0};
    logic [63:0] m_vec = '0;
    bit          m_valid = 1'b0, m_endrow = 1'b0, m_fm = 1'b0, m_rd = 1'b0, m_err = 1'b0;
    int          m_row = 0;

    task automatic modelRun(input logic [8:0] w);
        if (w & C_START) begin
            m_win = '{16'h0, 16'h0, 16'h0, 16'h0};
            m_row = 0;
        end
        if ((w & C_SKIP) && (w & C_NEXTDATA)) m_err = 1'b1;
        if (!(w & C_SKIP) && (w & C_NEXTDATA)) begin
            void'(m_win.pop_front());
            m_win.push_back(fifo_data);
        end else if (w & C_SHIFT) begin
            void'(m_win.pop_front());
            m_win.push_back(16'h0);
        end
        if (w & C_POP) begin
            for (int i = 0; i < 4; i++) m_vec[i*16 +: 16] = m_win[i];
            m_valid  = 1'b1;
            m_endrow = (w & C_ENDROW) != 0;
        end
        if ((w & C_NEXTROW) && m_row < 1023) m_row = m_row + 1;
        if (w & C_NEXTFM) begin
            m_fm  = 1'b1;
            m_row = 0;
        end
        if (w & C_NEXTREAD) m_rd = 1'b1;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_run = 0; m_wait = 0; m_held = '0; m_vec = '0; m_row = 0;
            m_valid = 0; m_endrow = 0; m_fm = 0; m_rd = 0; m_err = 0;
            m_win = '{16'h0, 16'h0, 16'h0, 16'h0};
        end else begin
            m_valid = 0; m_endrow = 0; m_fm = 0; m_rd = 0;
            if (!m_run) begin
                if (ctrl & C_START) begin
                    m_run = 1'b1;
                    m_win = '{16'h0, 16'h0, 16'h0, 16'h0};
                    m_row = 0;
                end else if (ctrl != 0) m_err = 1'b1;
            end else if (m_wait) begin
                if (ctrl != 0) m_err = 1'b1;
                if (!fifo_empty) begin
                    m_wait = 1'b0;
                    modelRun(m_held);
                end
            end else if (ctrl != 0) begin
                if ((ctrl & (C_SKIP | C_NEXTDATA)) && fifo_empty) begin
                    m_held = ctrl;
                    m_wait = 1'b1;
                end else modelRun(ctrl);
            end
        end
    end

    function automatic bit expPop();
        if (m_wait) return !fifo_empty && ((m_held & (C_SKIP | C_NEXTDATA)) != 0);
        if (m_run && !fifo_empty) return (ctrl & (C_SKIP | C_NEXTDATA)) != 0;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("ready", {63'h0, vectorgen_ready}, {63'h0, !m_wait});
            checkOutput("fifo_pop", {63'h0, fifo_pop}, {63'h0, expPop()});
            checkOutput("vector_out", vector_out, m_vec);
            checkOutput("vector_valid", {63'h0, vector_valid}, {63'h0, m_valid});
            checkOutput("vector_endrow", {63'h0, vector_endrow}, {63'h0, m_endrow});
            checkOutput("fm_done", {63'h0, fm_done}, {63'h0, m_fm});
            checkOutput("rd_req", {63'h0, rd_req}, {63'h0, m_rd});
            checkOutput("row_count", {54'h0, row_count}, 64'(m_row));
            checkOutput("protocol_err", {63'h0, protocol_err}, {63'h0, m_err});
        end
    end

    task automatic applyStimulus(input logic [8:0] w);
        ctrl = w;
        @(posedge clk);
        #2;
        ctrl = '0;
    endtask

    task automatic pushFifo(input logic [15:0] d);
        fifo_q.push_back(d);
        refreshFifo();
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        fifo_q.delete();
        refreshFifo();
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        int pops_before;
        @(posedge clk);
        #2;
        cmp_en = 1'b1;
        checkOutput("reset_ready", {63'h0, vectorgen_ready}, 64'h1);
        checkOutput("reset_valid", {63'h0, vector_valid}, 64'h0);
        checkOutput("reset_err", {63'h0, protocol_err}, 64'h0);
        reset_n = 1'b1;

        // Scenario 1: start, four nextData words, then pop.
        applyStimulus(C_START);
        for (int i = 1; i <= 4; i++) pushFifo(16'(i));
        pops_before = pop_total;
        for (int i = 0; i < 4; i++) applyStimulus(C_NEXTDATA);
        checkOutput("s1_pop_count", 64'(pop_total - pops_before), 64'd4);
        applyStimulus(C_POP);
        checkOutput("s1_vector", vector_out, 64'h0004_0003_0002_0001);
        checkOutput("s1_valid", {63'h0, vector_valid}, 64'h1);
        applyStimulus('0);
        checkOutput("s1_valid_drop", {63'h0, vector_valid}, 64'h0);

        // Scenario 3: padding shift and end-of-row vector.
        applyStimulus(C_SHIFT | C_POP);
        checkOutput("s3_shift_vec", vector_out, 64'h0000_0004_0003_0002);
        applyStimulus(C_ENDROW | C_POP);
        checkOutput("s3_endrow", {63'h0, vector_endrow}, 64'h1);
        checkOutput("s3_endrow_valid", {63'h0, vector_valid}, 64'h1);
        checkOutput("s3_endrow_vec", vector_out, 64'h0000_0004_0003_0002);

        // Scenario 2: nextData against an empty FIFO stalls until data arrives.
        pops_before = pop_total;
        applyStimulus(C_NEXTDATA);
        for (int i = 0; i < 5; i++) begin
            checkOutput("s2_stall_ready", {63'h0, vectorgen_ready}, 64'h0);
            applyStimulus('0);
        end
        checkOutput("s2_no_pop", 64'(pop_total - pops_before), 64'd0);
        pushFifo(16'h00AA);
        #1;
        checkOutput("s2_pop_now", {63'h0, fifo_pop}, 64'h1);
        applyStimulus('0);
        checkOutput("s2_ready_back", {63'h0, vectorgen_ready}, 64'h1);
        checkOutput("s2_single_pop", 64'(pop_total - pops_before), 64'd1);
        applyStimulus(C_POP);
        checkOutput("s2_vector", vector_out, 64'h00AA_0000_0004_0003);

        // Scenario 4: row counting, feature-map end and read request.
        for (int i = 0; i < 3; i++) applyStimulus(C_NEXTROW);
        checkOutput("s4_row3", {54'h0, row_count}, 64'd3);
        applyStimulus(C_NEXTFM);
        checkOutput("s4_row0", {54'h0, row_count}, 64'd0);
        checkOutput("s4_fm_done", {63'h0, fm_done}, 64'h1);
        applyStimulus(C_NEXTREAD);
        checkOutput("s4_fm_drop", {63'h0, fm_done}, 64'h0);
        checkOutput("s4_rd_req", {63'h0, rd_req}, 64'h1);
        applyStimulus('0);
        checkOutput("s4_rd_drop", {63'h0, rd_req}, 64'h0);

        // Scenario 5: protocol violations are sticky.
        doReset();
        applyStimulus(C_POP);
        checkOutput("s5_pop_idle_err", {63'h0, protocol_err}, 64'h1);
        for (int i = 0; i < 3; i++) applyStimulus('0);
        checkOutput("s5_err_sticky", {63'h0, protocol_err}, 64'h1);
        doReset();
        applyStimulus(C_START);
        applyStimulus(C_NEXTDATA);
        checkOutput("s5_no_err_yet", {63'h0, protocol_err}, 64'h0);
        applyStimulus(C_POP);
        checkOutput("s5_stall_err", {63'h0, protocol_err}, 64'h1);
        pushFifo(16'h0055);
        applyStimulus('0);
        applyStimulus(C_POP);
        checkOutput("s5_stall_vec", vector_out, 64'h0055_0000_0000_0000);
        doReset();
        applyStimulus(C_START);
        pushFifo(16'h0011);
        pushFifo(16'h0022);
        pops_before = pop_total;
        applyStimulus(C_SKIP | C_NEXTDATA);
        checkOutput("s5_both_err", {63'h0, protocol_err}, 64'h1);
        applyStimulus('0);
        checkOutput("s5_one_pop", 64'(pop_total - pops_before), 64'd1);
        checkOutput("s5_fifo_left", 64'(fifo_q.size()), 64'd1);
        applyStimulus(C_POP);
        checkOutput("s5_window_kept", vector_out, 64'h0);

        // Scenario 6: asynchronous reset while stalled discards the pending word.
        doReset();
        applyStimulus(C_START);
        applyStimulus(C_NEXTDATA);
        checkOutput("s6_stalled", {63'h0, vectorgen_ready}, 64'h0);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("s6_async_ready", {63'h0, vectorgen_ready}, 64'h1);
        checkOutput("s6_async_row", {54'h0, row_count}, 64'd0);
        checkOutput("s6_async_err", {63'h0, protocol_err}, 64'h0);
        pops_before = pop_total;
        pushFifo(16'h0077);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus('0);
        checkOutput("s6_no_pop", 64'(pop_total - pops_before), 64'd0);
        checkOutput("s6_fifo_kept", 64'(fifo_q.size()), 64'd1);

        @(posedge clk);
        #2;
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
